multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM for a multicycle RV32I(+M) core.
module multicycle_control #(
  parameter bit MEM_WAIT = 1'b0,
  parameter bit M_EXT    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       funct7b0,
  input  logic       Zero,
  input  logic       CarryOut,
  input  logic       Overflow,
  input  logic       Sign,
  input  logic       mem_ready,
  input  logic       md_done,
  output logic [2:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [3:0] ALUControl,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       mem_req,
  output logic       md_start,
  output logic       trap,
  output logic [3:0] state_dbg
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
    ALUWB, BRANCH, JAL, JALR, LUI, AUIPC, MDWAIT, TRAP
  } state_t;
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND = 4'd2, OR = 4'd3, XOR = 4'd4, SLT = 4'd5,
                         SLTU = 4'd6, SLL = 4'd7, SRL = 4'd8, SRA = 4'd9, PASSB = 4'd10;
  state_t state_q, state_d;
  logic ready, take, alu_bad, md_ok;
  logic [3:0] alu_op;
  always_ff @(posedge clk)
    state_q <= !rst_n ? FETCH : state_d;
  assign state_dbg = state_q;
  assign trap = state_q == TRAP;
  assign ready = MEM_WAIT ? mem_ready : 1'b1;
  assign md_ok = M_EXT && !funct7b5;
  // OP only permits funct7b5 on add/sub and srl/sra; OP-IMM only forbids it on slli
  assign alu_bad = funct7b5 && (op[5] ? !(funct3 == 3'b000 || funct3 == 3'b101) : funct3 == 3'b001);
  assign ImmSrc = op == 7'b0100011 ? 3'b001 :
                  op == 7'b1100011 ? 3'b010 :
                  op == 7'b1101111 ? 3'b011 :
                  (op == 7'b0110111 || op == 7'b0010111) ? 3'b100 : 3'b000;
  always_comb begin
    case (funct3)
      3'b000:  alu_op = (op[5] && funct7b5) ? SUB : ADD;
      3'b001:  alu_op = SLL;
      3'b010:  alu_op = SLT;
      3'b011:  alu_op = SLTU;
      3'b100:  alu_op = XOR;
      3'b101:  alu_op = funct7b5 ? SRA : SRL;
      3'b110:  alu_op = OR;
      default: alu_op = AND;
    endcase
    case (funct3)
      3'b000:  take = Zero;
      3'b001:  take = ~Zero;
      3'b100:  take = Sign ^ Overflow;
      3'b101:  take = ~(Sign ^ Overflow);
      3'b110:  take = ~CarryOut;
      3'b111:  take = CarryOut;
      default: take = 1'b0;
    endcase
  end
  // Strobes are forced low while rst_n is low so an in-flight access never completes
  always_comb begin
    state_d = state_q;
    ALUSrcA = 2'b00;
    ALUSrcB = 2'b00;
    ResultSrc = 2'b00;
    ALUControl = ADD;
    AdrSrc = 1'b0;
    IRWrite = 1'b0;
    PCWrite = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    mem_req = 1'b0;
    md_start = 1'b0;
    if (rst_n)
      case (state_q)
        FETCH: begin
          mem_req = 1'b1;
          ALUSrcB = 2'b10;
          ResultSrc = 2'b10;
          IRWrite = ready;
          PCWrite = ready;
          state_d = ready ? DECODE : FETCH;
        end
        DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          case (op)
            7'b0000011, 7'b0100011: state_d = MEMADR;
            7'b0110011: state_d = EXECR;
            7'b0010011: state_d = EXECI;
            7'b1100011: state_d = BRANCH;
            7'b1101111: state_d = JAL;
            7'b1100111: state_d = JALR;
            7'b0110111: state_d = LUI;
            7'b0010111: state_d = AUIPC;
            default:    state_d = TRAP;
          endcase
        end
        MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          state_d = op[5] ? MEMWRITE : MEMREAD;
        end
        MEMREAD: begin
          AdrSrc = 1'b1;
          mem_req = 1'b1;
          state_d = ready ? MEMWB : MEMREAD;
        end
        MEMWRITE: begin
          AdrSrc = 1'b1;
          mem_req = 1'b1;
          MemWrite = ready;
          state_d = ready ? FETCH : MEMWRITE;
        end
        MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite = 1'b1;
          state_d = FETCH;
        end
        EXECR: begin
          ALUSrcA = 2'b10;
          ALUControl = alu_op;
          md_start = funct7b0 && md_ok;
          state_d = funct7b0 ? (md_ok ? MDWAIT : TRAP) : (alu_bad ? TRAP : ALUWB);
        end
        EXECI: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ALUControl = alu_op;
          state_d = alu_bad ? TRAP : ALUWB;
        end
        ALUWB: begin
          RegWrite = 1'b1;
          state_d = FETCH;
        end
        BRANCH: begin
          ALUSrcA = 2'b10;
          ALUControl = SUB;
          PCWrite = take;
          state_d = funct3[2:1] == 2'b01 ? TRAP : FETCH;
        end
        JAL: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b10;
          PCWrite = 1'b1;
          state_d = ALUWB;
        end
        JALR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ResultSrc = 2'b10;
          PCWrite = 1'b1;
          state_d = ALUWB;
        end
        LUI: begin
          ALUSrcB = 2'b01;
          ALUControl = PASSB;
          state_d = ALUWB;
        end
        AUIPC: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
          state_d = ALUWB;
        end
        MDWAIT: begin
          ResultSrc = md_done ? 2'b11 : 2'b00;
          RegWrite = md_done;
          state_d = md_done ? FETCH : MDWAIT;
        end
        TRAP: state_d = TRAP;
      endcase
  end
endmodule
